// File: rtl/datapath_p_pkg.sv
// Shared definitions for the datapath_p slice: opcode encodings, the
// sequencing FSM state type, and the bit positions of the flags inside flags_out.
package datapath_p_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_MVA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_SHL = 4'hC;
  localparam logic [3:0] OP_SHR = 4'hD;
  localparam logic [3:0] OP_CMP = 4'hE;
  localparam logic [3:0] OP_OUT = 4'hF;

  typedef enum logic {IDLE, LD_WB} state_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;

endpackage

// File: rtl/datapath_p_if.sv
// Sequencer <-> datapath bundle.
//   master (sequencer): drives instr_valid/instr, observes everything else.
//   slave  (datapath) : accepts instructions, publishes acc/flags/out/err.
interface datapath_p_if #(parameter int DW = 4);
  localparam int INSTR_W = 4 + DW;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [DW-1:0]      acc_out;
  logic [1:0]         flags_out;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               err;

  modport master (
    output instr_valid, instr,
    input  instr_ready, acc_out, flags_out, out_valid, out_data, err
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, acc_out, flags_out, out_valid, out_data, err
  );
endinterface

// File: rtl/datapath_p_alu.sv
// Combinational ALU for datapath_p.
//   opcode : instruction opcode (only ALU opcodes produce a non-passthrough result)
//   a, b   : accumulator and register-bus operands
//   result : DW-bit result (modulo 2^DW); carry: carry/borrow/shifted-out bit
//   zero   : result == 0
module alu_p
  import datapath_p_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the unsigned borrow (a < b).
    diff   = {1'b0, a} - {1'b0, b};
    result = a;
    carry  = 1'b0;
    case (opcode)
      OP_ADD:         begin result = sum[DW-1:0];  carry = sum[DW];  end
      OP_SUB, OP_CMP: begin result = diff[DW-1:0]; carry = diff[DW]; end
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_NOT:         result = ~a;
      OP_SHL:         {carry, result} = {a, 1'b0};
      OP_SHR:         {result, carry} = {1'b0, a};
      default:        ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/datapath_p.sv
// Parametrised accumulator datapath.
//   clk, grst : clock and synchronous active-high reset
//   dp        : slave side of datapath_p_if (instruction handshake, acc_out,
//               flags_out {C,Z}, out_valid/out_data OUT port, err pulse)
// Instructions are accepted on instr_valid && instr_ready; every op completes
// on its accept edge except LD, which reads RAM synchronously and writes acc
// back in the following LD_WB cycle while instr_ready is held low.
module datapath_p
  import datapath_p_pkg::*;
#(
  parameter int DW    = 4,
  parameter int NREG  = 4,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         grst,
  datapath_p_if.slave  dp
);

  localparam int INSTR_W = 4 + DW;
  localparam int RIW     = (NREG  > 1) ? $clog2(NREG)  : 1;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [1:0]    flags_q, flags_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic [3:0]     opcode;
  logic [DW-1:0]  operand;
  logic           reg_ok, addr_ok, accept, mem_we, uses_reg, uses_addr;
  logic [RIW-1:0] reg_idx;
  logic [AW-1:0]  addr_idx;
  logic [DW-1:0]  reg_rd, bus;
  logic [DW-1:0]  alu_result;
  logic           alu_carry, alu_zero;

  assign opcode   = dp.instr[INSTR_W-1 -: 4];
  assign operand  = dp.instr[DW-1:0];
  assign reg_ok   = int'(operand) < NREG;
  assign addr_ok  = int'(operand) < DEPTH;
  assign reg_idx  = operand[RIW-1:0];
  assign addr_idx = operand[AW-1:0];
  assign reg_rd   = reg_ok ? regs_q[reg_idx] : '0;
  assign accept   = dp.instr_valid && (state_q == IDLE) && !grst;

  alu_p #(.DW(DW)) u_alu (
    .opcode (opcode),
    .a      (acc_q),
    .b      (reg_rd),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Internal bus: single source for everything that lands in acc.
  always_comb begin
    bus = alu_result;
    if (state_q == LD_WB) bus = rd_data_q;
    else if (opcode == OP_LDI) bus = operand;
    else if (opcode == OP_MVA) bus = reg_rd;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    flags_d     = flags_q;
    regs_d      = regs_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    rd_data_d   = rd_data_q;
    mem_we      = 1'b0;
    uses_reg    = 1'b0;
    uses_addr   = 1'b0;
    if (state_q == LD_WB) begin
      acc_d           = bus;
      flags_d[FLAG_Z] = (bus == '0);
      state_d         = IDLE;
    end else if (accept) begin
      case (opcode)
        OP_LDI, OP_MVA: begin
          acc_d           = bus;
          flags_d[FLAG_Z] = (bus == '0);
        end
        OP_MOV: if (reg_ok) regs_d[reg_idx] = acc_q;
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
          acc_d           = bus;
          flags_d[FLAG_C] = alu_carry;
          flags_d[FLAG_Z] = alu_zero;
        end
        OP_CMP: begin
          flags_d[FLAG_C] = alu_carry;
          flags_d[FLAG_Z] = alu_zero;
        end
        OP_LD: begin
          rd_data_d = addr_ok ? mem_q[addr_idx] : '0;
          state_d   = LD_WB;
        end
        OP_ST:  mem_we = addr_ok;
        OP_OUT: begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
      uses_reg  = (opcode inside {OP_MOV, OP_MVA, OP_ADD, OP_SUB, OP_AND,
                                  OP_OR, OP_XOR, OP_CMP});
      uses_addr = (opcode inside {OP_LD, OP_ST});
      err_d     = (uses_reg && !reg_ok) || (uses_addr && !addr_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (grst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      flags_q     <= '0;
      regs_q      <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      flags_q     <= flags_d;
      regs_q      <= regs_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_idx] <= acc_q;
  end

  assign dp.instr_ready = (state_q == IDLE);
  assign dp.acc_out     = acc_q;
  assign dp.flags_out   = flags_q;
  assign dp.out_valid   = out_valid_q;
  assign dp.out_data    = out_data_q;
  assign dp.err         = err_q;

endmodule

// File: tb/tb_datapath_p.sv
module tb_datapath_p;
  import datapath_p_pkg::*;

  logic clk = 1'b0;
  logic grst;
  always #5 clk = ~clk;

  datapath_p_if #(.DW(4)) dif ();
  datapath_p_if #(.DW(4)) dif8 ();

  datapath_p #(.DW(4), .NREG(4), .DEPTH(16)) dut (
    .clk(clk), .grst(grst), .dp(dif)
  );
  datapath_p #(.DW(4), .NREG(4), .DEPTH(8)) dut8 (
    .clk(clk), .grst(grst), .dp(dif8)
  );

  int checks = 0;
  int errors = 0;

  // Reference model (DW=4, NREG=4, DEPTH=16), plain integer arithmetic.
  int m_acc, m_out;
  bit m_c, m_z;
  int m_regs [4];
  int m_mem  [16];
  bit e_err, e_outv;

  // Observation from the last drive().
  logic [13:0] obs;
  logic        err8;

  function automatic void model_reset();
    m_acc = 0; m_out = 0; m_c = 0; m_z = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
  endfunction

  function automatic void model_exec(input int op, input int opd);
    int rv;
    bit rok;
    rok    = opd < 4;
    rv     = 0;
    if (rok) rv = m_regs[opd];
    e_err  = 0;
    e_outv = 0;
    case (op)
      1:  begin m_acc = opd; m_z = (m_acc == 0); end
      2:  begin if (rok) m_regs[opd] = m_acc; e_err = !rok; end
      3:  begin m_acc = rv; m_z = (m_acc == 0); e_err = !rok; end
      4:  begin m_c = (m_acc + rv) > 15; m_acc = (m_acc + rv) % 16;
                m_z = (m_acc == 0); e_err = !rok; end
      5:  begin m_c = m_acc < rv; m_acc = (m_acc - rv) & 15;
                m_z = (m_acc == 0); e_err = !rok; end
      6:  begin m_acc = m_acc & rv; m_c = 0; m_z = (m_acc == 0); e_err = !rok; end
      7:  begin m_acc = m_acc | rv; m_c = 0; m_z = (m_acc == 0); e_err = !rok; end
      8:  begin m_acc = m_acc ^ rv; m_c = 0; m_z = (m_acc == 0); e_err = !rok; end
      9:  begin m_acc = 15 - m_acc; m_c = 0; m_z = (m_acc == 0); end
      10: begin m_acc = m_mem[opd]; m_z = (m_acc == 0); end
      11: m_mem[opd] = m_acc;
      12: begin m_c = m_acc >= 8; m_acc = (m_acc * 2) % 16; m_z = (m_acc == 0); end
      13: begin m_c = (m_acc % 2) == 1; m_acc = m_acc / 2; m_z = (m_acc == 0); end
      14: begin m_c = m_acc < rv; m_z = (m_acc == rv); e_err = !rok; end
      15: begin m_out = m_acc; e_outv = 1; end
      default: ;
    endcase
  endfunction

  // {ready before, ready after accept, err, out_valid, out_data, acc, C, Z}
  function automatic logic [13:0] exp_vec(input int op);
    return {1'b1, (op != 10), e_err, e_outv, m_out[3:0], m_acc[3:0], m_c, m_z};
  endfunction

  // Issues one instruction; for LD a junk LDI is held valid during LD_WB.
  task automatic drive(input logic [3:0] op, input logic [3:0] opd);
    logic rdy_seen, rdy_after, err_seen, outv_seen;
    logic [3:0] outd_seen;
    rdy_seen        = dif.instr_ready;
    dif.instr_valid = 1'b1;
    dif.instr       = {op, opd};
    @(posedge clk); #1;
    rdy_after = dif.instr_ready;
    err_seen  = dif.err;
    outv_seen = dif.out_valid;
    outd_seen = dif.out_data;
    if (op == OP_LD) begin
      dif.instr = {OP_LDI, 4'h7};
      @(posedge clk); #1;
    end
    dif.instr_valid = 1'b0;
    obs = {rdy_seen, rdy_after, err_seen, outv_seen, outd_seen, dif.acc_out, dif.flags_out};
  endtask

  task automatic drive8(input logic [3:0] op, input logic [3:0] opd);
    dif8.instr_valid = 1'b1;
    dif8.instr       = {op, opd};
    @(posedge clk); #1;
    err8 = dif8.err;
    dif8.instr_valid = 1'b0;
    if (op == OP_LD) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    grst = 1'b1;
    dif.instr_valid = 1'b1;
    dif.instr       = {OP_LDI, 4'h7};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dif.acc_out, dif.flags_out, dif.instr_ready, dif.out_valid, dif.err} !== 9'b0000_00_1_0_0) begin
      errors++;
      $display("FAIL reset_held: acc=%h flags=%b rdy=%b ov=%b err=%b required 0 00 1 0 0",
               dif.acc_out, dif.flags_out, dif.instr_ready, dif.out_valid, dif.err);
    end
    grst = 1'b0;
    dif.instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({dif.acc_out, dif.flags_out, dif.instr_ready, dif.out_valid, dif.err, dif.out_data} !== 13'b0000_00_1_0_0_0000) begin
      errors++;
      $display("FAIL reset_release: acc=%h flags=%b rdy=%b ov=%b err=%b od=%h required all 0, rdy=1",
               dif.acc_out, dif.flags_out, dif.instr_ready, dif.out_valid, dif.err, dif.out_data);
    end
    model_reset();
  endtask

  task automatic test_alu_seq();
    logic [7:0] prog [15] = '{8'h19, 8'h20, 8'h18, 8'h40, 8'h13, 8'h21, 8'h13, 8'hE1,
                              8'h12, 8'h51, 8'h1A, 8'hF0, 8'hD0, 8'hC0, 8'hC0};
    for (int i = 0; i < 15; i++) begin
      drive(prog[i][7:4], prog[i][3:0]);
      model_exec(prog[i][7:4], prog[i][3:0]);
      checks++;
      if (obs !== exp_vec(prog[i][7:4])) begin
        errors++;
        $display("FAIL alu_seq step %0d instr=%h: got %b required %b", i, prog[i], obs, exp_vec(prog[i][7:4]));
      end
      if (i == 3) begin
        checks++;
        if (obs[5:0] !== 6'b0001_10) begin
          errors++;
          $display("FAIL add_carry: acc/flags=%b required 000110", obs[5:0]);
        end
      end
    end
  endtask

  task automatic test_load_store();
    logic [7:0] prog [4] = '{8'h15, 8'hB3, 8'h10, 8'hA3};
    for (int i = 0; i < 4; i++) begin
      drive(prog[i][7:4], prog[i][3:0]);
      model_exec(prog[i][7:4], prog[i][3:0]);
      checks++;
      if (obs !== exp_vec(prog[i][7:4])) begin
        errors++;
        $display("FAIL load_store step %0d instr=%h: got %b required %b", i, prog[i], obs, exp_vec(prog[i][7:4]));
      end
    end
    checks++;
    if (dif.acc_out !== 4'h5 || dif.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ld_result: acc=%h rdy=%b required 5 1", dif.acc_out, dif.instr_ready);
    end
  endtask

  task automatic test_range_errors();
    logic [7:0] prog [7] = '{8'h17, 8'h26, 8'h36, 8'h30, 8'h31, 8'h32, 8'h33};
    for (int i = 0; i < 7; i++) begin
      drive(prog[i][7:4], prog[i][3:0]);
      model_exec(prog[i][7:4], prog[i][3:0]);
      checks++;
      if (obs !== exp_vec(prog[i][7:4])) begin
        errors++;
        $display("FAIL range step %0d instr=%h: got %b required %b", i, prog[i], obs, exp_vec(prog[i][7:4]));
      end
    end
    drive8(OP_LDI, 4'h3);
    drive8(OP_ST, 4'h1);
    drive8(OP_LDI, 4'h6);
    drive8(OP_ST, 4'h9);
    checks++;
    if (err8 !== 1'b1) begin
      errors++;
      $display("FAIL depth8_st_err: err=%b required 1", err8);
    end
    drive8(OP_LD, 4'h1);
    checks++;
    if ({err8, dif8.acc_out, dif8.flags_out[FLAG_Z]} !== 6'b0_0011_0) begin
      errors++;
      $display("FAIL depth8_no_alias: err=%b acc=%h Z=%b required 0 3 0", err8, dif8.acc_out, dif8.flags_out[FLAG_Z]);
    end
    drive8(OP_LD, 4'hC);
    checks++;
    if ({err8, dif8.acc_out, dif8.flags_out[FLAG_Z]} !== 6'b1_0000_1) begin
      errors++;
      $display("FAIL depth8_ld_err: err=%b acc=%h Z=%b required 1 0 1", err8, dif8.acc_out, dif8.flags_out[FLAG_Z]);
    end
  endtask

  task automatic test_random();
    int op, opd;
    for (int a = 0; a < 16; a++) begin
      opd = $urandom_range(0, 15);
      drive(OP_LDI, 4'(opd));
      model_exec(1, opd);
      drive(OP_ST, 4'(a));
      model_exec(11, a);
      checks++;
      if (obs !== exp_vec(11)) begin
        errors++;
        $display("FAIL mem_fill addr %0d: got %b required %b", a, obs, exp_vec(11));
      end
    end
    for (int i = 0; i < 400; i++) begin
      op  = $urandom_range(0, 15);
      opd = $urandom_range(0, 15);
      drive(4'(op), 4'(opd));
      model_exec(op, opd);
      checks++;
      if (obs !== exp_vec(op)) begin
        errors++;
        $display("FAIL random %0d op=%h opd=%h: got %b required %b", i, op, opd, obs, exp_vec(op));
      end
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        checks++;
        if ({dif.acc_out, dif.flags_out, dif.out_valid, dif.err} !== {m_acc[3:0], m_c, m_z, 2'b00}) begin
          errors++;
          $display("FAIL idle %0d: acc=%h flags=%b ov=%b err=%b required acc=%h", i,
                   dif.acc_out, dif.flags_out, dif.out_valid, dif.err, m_acc[3:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    drive(OP_LDI, 4'h5); model_exec(1, 5);
    drive(OP_ST, 4'h2);  model_exec(11, 2);
    dif.instr_valid = 1'b1;
    dif.instr       = {OP_LD, 4'h2};
    @(posedge clk); #1;
    checks++;
    if (dif.instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ld_busy: rdy=%b required 0", dif.instr_ready);
    end
    dif.instr = {OP_LDI, 4'h7};
    grst = 1'b1;
    @(posedge clk); #1;
    grst = 1'b0;
    dif.instr_valid = 1'b0;
    model_reset();
    checks++;
    if ({dif.acc_out, dif.flags_out, dif.instr_ready, dif.out_valid, dif.err} !== 9'b0000_00_1_0_0) begin
      errors++;
      $display("FAIL reset_in_ld: acc=%h flags=%b rdy=%b ov=%b err=%b required 0 00 1 0 0",
               dif.acc_out, dif.flags_out, dif.instr_ready, dif.out_valid, dif.err);
    end
    drive(OP_MVA, 4'h0);
    model_exec(3, 0);
    checks++;
    if (obs !== exp_vec(3)) begin
      errors++;
      $display("FAIL after_reset_mva: got %b required %b", obs, exp_vec(3));
    end
  endtask

  initial begin
    grst = 1'b1;
    dif.instr_valid  = 1'b0;
    dif.instr        = '0;
    dif8.instr_valid = 1'b0;
    dif8.instr       = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    test_reset();
    test_alu_seq();
    test_load_store();
    test_range_errors();
    test_random();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
